relprime_engine: RTL and testbench
==================================

// Module: relprime_engine
// PURPOSE
//  - Parametrised hardware relprime unit. On start it finds the smallest m >= 2 with gcd(n, m) == 1 for operand n.
//  - Multi-cycle FSM using one-step-per-cycle subtractive Euclid.
//  - Successor to the fixed 16-bit relprime path in top_level: generic width, explicit busy/error, reset.
//  - Sits beside the processor datapath as a memory-free accelerator.
// PARAMETERS
//  - WIDTH  16  operand/result width in bits (>= 4)
// PORTS
//  - CLK             in   1      system clock, rising edge
//  - RST_N           in   1      asynchronous, active-low reset
//  - start           in   1      request; sampled only in IDLE or DONE
//  - register_value  in   WIDTH  operand n; captured on the accepted-start edge
//  - out             out  WIDTH  result m; valid while relprime_out == 1
//  - relprime_out    out  1      done flag
//  - busy            out  1      high in LOAD/GCD/CHECK
//  - error           out  1      result invalid (n == 0, or m overflow); qualifies relprime_out
// BEHAVIOUR
//  - Reset (RST_N low, async): state=IDLE; out, relprime_out, busy, error = 0; internal n_r/m_r/a/b = 0.
//  - Width rule: a, b, m_r are WIDTH bits; all arithmetic is unsigned and never exceeds WIDTH.
//  - States:
//    - IDLE: start=1 -> n_r<=register_value, LOAD.
//    - LOAD:
//      - n_r==0 -> error<=1, out<=0, DONE.
//      - else m_r<=2, a<=n_r, b<=2, GCD.
//    - GCD, one action per cycle:
//      - b==0 -> CHECK (gcd held in a).
//      - a>=b -> a<=a-b.
//      - a<b  -> a<=b, b<=a (swap).
//    - CHECK:
//      - a==1 -> out<=m_r, DONE.
//      - m_r==all-ones -> error<=1, out<=0, DONE.
//      - else m_r<=m_r+1, a<=n_r, b<=m_r+1, GCD.
//    - DONE: relprime_out=1, out/error held.
//      - start=1 -> clear relprime_out and error, capture n, LOAD (back-to-back restart).
//      - start=0 -> hold indefinitely.
//  - start is level-sampled, not edge-detected.
//    - Held high across DONE -> immediate restart on the same operand.
//    - Ignored while busy=1; operand changes mid-run have no effect.
//  - Latency:
//    - Accepted start -> relprime_out rise >= 4 cycles.
//    - Data-dependent, bounded by the sum over candidates of Euclid steps.
//    - No timeout.
//  - relprime_out, out, error are registered (change only on CLK rise or reset).
//  - RST_N asserted mid-operation aborts immediately to the reset values above; no partial result is exposed.
//  - n==1 -> m=2. n odd -> m=2. n even -> first odd coprime >= 3.
// CONFIGURATION
//  - RELPRIME_CYCLE_COUNT_EN defined:
//    - Adds output cycle_count [31:0].
//    - Cleared on accepted start; +1 per cycle while busy; frozen in DONE; saturates at all-ones; reset to 0.
//  - Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  - Reset: RST_N=0 with start=1 -> all outputs 0, state IDLE; release -> IDLE until next start.
//  - Sequence, start pulse 4 cycles then low, wait relprime_out, check error==0:
//    - n=5040 -> out=11
//    - n=4620 -> out=13
//    - n=36432 -> out=5
//    - n=25534 -> out=3
//    - n=4590 -> out=7
//  - Edge operands:
//    - n=1 -> out=2, error=0.
//    - n=0 -> relprime_out=1, error=1, out=0.
//    - n=65535 -> out=2.
//  - Handshake:
//    - register_value changed and start re-pulsed while busy -> result still for original n.
//    - start held high -> relprime_out pulses 1 cycle per repeated run, result stable.
//  - Mid-run reset: assert RST_N low in GCD for n=4620 -> outputs 0 at once.
//    - Re-run n=4620 -> 13.
//  - WIDTH=8 build: n=210 -> out=11; with RELPRIME_CYCLE_COUNT_EN, cycle_count>0 and stable in DONE.

Source files
------------

// File: rtl/relprime_engine.sv
// relprime_engine
//   Finds the smallest m >= 2 such that gcd(n, m) == 1 for an operand n.
//   Each candidate m is tested with a subtractive Euclid that does one
//   subtract or swap per clock.
//   The engine needs no memory. It sits beside the processor datapath.
//
// Parameters
//   WIDTH           operand/result width in bits (>= 4)
//
// Ports
//   CLK             in   1      system clock, rising edge
//   RST_N           in   1      asynchronous active-low reset
//   start           in   1      run request, level-sampled in IDLE or DONE
//   register_value  in   WIDTH  operand n, captured when start is accepted
//   out             out  WIDTH  result m, valid while relprime_out == 1
//   relprime_out    out  1      done flag (high in DONE)
//   busy            out  1      high while in LOAD/GCD/CHECK
//   error           out  1      result invalid (n == 0 or m overflow)
//   cycle_count     out  32     only with RELPRIME_CYCLE_COUNT_EN: busy cycles
//                               of the current/last run, saturating
//
// Optional feature macro: RELPRIME_CYCLE_COUNT_EN
module relprime_engine #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [WIDTH-1:0] register_value,
   output logic [WIDTH-1:0] out,
   output logic             relprime_out,
   output logic             busy,
   output logic             error
`ifdef RELPRIME_CYCLE_COUNT_EN
   ,
   output logic [31:0]      cycle_count
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      GCD,
      CHECK,
      DONE
   } state_t;

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] n_r;
   logic [WIDTH-1:0] m_r;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;

   // A new run can only begin from IDLE or DONE.
   logic start_accept;
   assign start_accept = start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state        <= IDLE;
         n_r          <= '0;
         m_r          <= '0;
         a            <= '0;
         b            <= '0;
         out          <= '0;
         relprime_out <= 1'b0;
         busy         <= 1'b0;
         error        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  n_r   <= register_value;
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end

            LOAD: begin
               if (n_r == '0) begin
                  // gcd(0, m) == m, so no m >= 2 can ever qualify.
                  error        <= 1'b1;
                  out          <= '0;
                  relprime_out <= 1'b1;
                  busy         <= 1'b0;
                  state        <= DONE;
               end else begin
                  m_r   <= TWO;
                  a     <= n_r;
                  b     <= TWO;
                  state <= GCD;
               end
            end

            GCD: begin
               // Subtractive Euclid. When b reaches zero, a holds the gcd.
               if (b == '0) begin
                  state <= CHECK;
               end else if (a >= b) begin
                  a <= a - b;
               end else begin
                  a <= b;
                  b <= a;
               end
            end

            CHECK: begin
               if (a == ONE) begin
                  out          <= m_r;
                  relprime_out <= 1'b1;
                  busy         <= 1'b0;
                  state        <= DONE;
               end else if (m_r == ALL_ONES) begin
                  // The next candidate would not fit in WIDTH bits.
                  error        <= 1'b1;
                  out          <= '0;
                  relprime_out <= 1'b1;
                  busy         <= 1'b0;
                  state        <= DONE;
               end else begin
                  m_r   <= m_r + ONE;
                  a     <= n_r;
                  b     <= m_r + ONE;
                  state <= GCD;
               end
            end

            DONE: begin
               // A level-high start restarts immediately. The result stays
               // visible for exactly one cycle between runs.
               if (start) begin
                  relprime_out <= 1'b0;
                  error        <= 1'b0;
                  n_r          <= register_value;
                  busy         <= 1'b1;
                  state        <= LOAD;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef RELPRIME_CYCLE_COUNT_EN
   // Counts the cycles in which busy is high. It is cleared on the accepting
   // edge, so the first busy cycle reads zero and increments from there.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cycle_count <= '0;
      end else if (start_accept) begin
         cycle_count <= '0;
      end else if (busy && (cycle_count != 32'hFFFF_FFFF)) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end
`else
   // start_accept is only needed by the optional counter.
   logic unused_accept;
   assign unused_accept = start_accept;
`endif

endmodule

// File: tb/tb_relprime_engine.sv
// Testbench for relprime_engine (WIDTH = 16).
// The driver pushes the expected result for each run into a scoreboard queue.
// A monitor pops from the queue and compares on every rising edge of
// relprime_out.
module tb_relprime_engine;

   localparam int W = 16;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] register_value = '0;
   logic [W-1:0] out;
   logic         relprime_out;
   logic         busy;
   logic         error;
`ifdef RELPRIME_CYCLE_COUNT_EN
   logic [31:0]  cycle_count;
`endif

   relprime_engine #(.WIDTH(W)) dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .start          (start),
      .register_value (register_value),
      .out            (out),
      .relprime_out   (relprime_out),
      .busy           (busy),
      .error          (error)
`ifdef RELPRIME_CYCLE_COUNT_EN
      ,
      .cycle_count    (cycle_count)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [W-1:0] n;
      logic [W-1:0] m;
      logic         err;
   } exp_t;

   int   vectors = 0;
   int   miscompares = 0;
   int   popped = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic prev_rel = 1'b0;

   // Reference model: plain modulo gcd over the candidates m = 2, 3, ...
   function automatic int gcd_int(int x, int y);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic exp_t ref_model(logic [W-1:0] n);
      exp_t e;
      e.n   = n;
      e.m   = '0;
      e.err = 1'b1;
      if (n != 0) begin
         for (int m = 2; m < (1 << W); m++) begin
            if (gcd_int(int'(n), m) == 1) begin
               e.m   = W'(m);
               e.err = 1'b0;
               break;
            end
         end
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: a rising edge of relprime_out marks one completed run.
   always @(negedge CLK) begin
      if (RST_N && relprime_out && !prev_rel) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_result actual out=%0d error=%0d required none", out, error);
         end else begin
            mon_e = sb.pop_front();
            popped++;
            if (out !== mon_e.m || error !== mon_e.err) begin
               miscompares++;
               $display("FAIL result n=%0d actual out=%0d error=%0d required out=%0d error=%0d",
                        mon_e.n, out, error, mon_e.m, mon_e.err);
            end else begin
               $display("result n=%0d out=%0d error=%0d ok", mon_e.n, out, error);
            end
         end
      end
      prev_rel = relprime_out;
   end

   task automatic push_exp(input logic [W-1:0] n, input logic [W-1:0] m, input logic err);
      exp_t e;
      e.n = n;
      e.m = m;
      e.err = err;
      sb.push_back(e);
   endtask

   task automatic wait_pops(input int target, input int budget);
      int cyc = 0;
      while (popped < target && cyc < budget) begin
         @(negedge CLK);
         #1;
         cyc++;
      end
      if (popped < target) check("timeout_wait_result", 32'(popped), 32'(target));
   endtask

   // One run: start is held for 'pulse' clock edges, then the task waits for the result.
   task automatic run(input logic [W-1:0] n, input logic [W-1:0] m, input logic err, input int pulse);
      int target;
      @(negedge CLK);
      target = popped + 1;
      push_exp(n, m, err);
      register_value = n;
      start = 1'b1;
      repeat (pulse) @(negedge CLK);
      start = 1'b0;
      wait_pops(target, 60000);
   endtask

   initial begin
      int   target;
      int   cyc;
      exp_t e;
      logic [W-1:0] rn;

      // Reset with start high: every output must stay zero.
      RST_N = 1'b0;
      start = 1'b1;
      register_value = W'(5040);
      repeat (3) @(negedge CLK);
      check("reset_out", 32'(out), 0);
      check("reset_relprime_out", 32'(relprime_out), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_error", 32'(error), 0);
      start = 1'b0;
      RST_N = 1'b1;
      repeat (5) @(negedge CLK);
      check("idle_busy", 32'(busy), 0);
      check("idle_relprime_out", 32'(relprime_out), 0);

      // Directed operands
      run(W'(5040), W'(11), 1'b0, 4);
      repeat (3) @(negedge CLK);
      check("done_hold_out", 32'(out), 11);
      check("done_hold_flag", 32'(relprime_out), 1);
      run(W'(1), W'(2), 1'b0, 4);
      run(W'(0), W'(0), 1'b1, 1);
      check("n0_flag", 32'(relprime_out), 1);
      run(W'(65535), W'(2), 1'b0, 4);

      // Handshake: the operand change and the second pulse arrive while busy.
      @(negedge CLK);
      target = popped + 1;
      push_exp(W'(210), W'(11), 1'b0);
      register_value = W'(210);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 1);
      check("flag_cleared_on_start", 32'(relprime_out), 0);
      repeat (3) @(negedge CLK);
      register_value = W'(77);
      start = 1'b1;
      repeat (2) @(negedge CLK);
      start = 1'b0;
      wait_pops(target, 60000);

      // start held high: three back-to-back runs, each with a one-cycle flag.
      @(negedge CLK);
      target = popped + 3;
      for (int i = 0; i < 3; i++) push_exp(W'(9), W'(2), 1'b0);
      register_value = W'(9);
      start = 1'b1;
      cyc = 0;
      while (popped < target && cyc < 5000) begin
         @(negedge CLK);
         #1;
         cyc++;
         if (popped < target && relprime_out) begin
            @(negedge CLK);
            #1;
            cyc++;
            check("held_pulse_width", 32'(relprime_out), 0);
         end
      end
      start = 1'b0;
      if (popped < target) check("timeout_held_start", 32'(popped), 32'(target));
      repeat (3) @(negedge CLK);
      check("held_final_flag", 32'(relprime_out), 1);
      check("held_final_out", 32'(out), 2);

      // Mid-run reset during the Euclid loop
      @(negedge CLK);
      register_value = W'(4620);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (10) @(negedge CLK);
      check("midrun_busy", 32'(busy), 1);
      #2;
      RST_N = 1'b0;
      #1;
      check("midrun_out", 32'(out), 0);
      check("midrun_flag", 32'(relprime_out), 0);
      check("midrun_busy_cleared", 32'(busy), 0);
      check("midrun_error", 32'(error), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      run(W'(4620), W'(13), 1'b0, 4);

      // Random small operands against the reference model
      for (int i = 0; i < 16; i++) begin
         rn = W'($urandom_range(0, 255));
         e = ref_model(rn);
         run(rn, e.m, e.err, (rn == 0) ? 1 : int'($urandom_range(1, 4)));
      end

      repeat (2) @(negedge CLK);
      check("scoreboard_empty", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
